udp_rx_parser: RTL and testbench

UDP_RX_PARSER -- requirements
Module: udp_rx_parser

---
 rtl/udp_rx_pkg.sv | 20 ++
 rtl/udp_rx_parser_sat_cnt.sv | 20 ++
 rtl/udp_rx_parser.sv | 182 ++++++++++++++++++
 tb/tb_udp_rx_parser.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive parser.
package udp_rx_pkg;

    localparam logic [15:0] UDP_HDR_LEN = 16'd8;
    localparam logic [7:0]  IPPROTO_UDP = 8'd17;
    localparam int          CNT_W       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        SKIP = 2'd3
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/udp_rx_parser_sat_cnt.sv
// 16-bit saturating event counter used for the drop/error diagnostics.
module sat_cnt
    import udp_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one event per pulse, holding at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= {CNT_W{1'b0}};
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/udp_rx_parser.sv
// UDP header parser: strips the 8-byte header from an IPv4 payload stream.
// Define UDP_LEN_CHECK_EN to trim the payload to the UDP length field.
module udp_rx_parser
    import udp_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ip_dout,
    input  logic             ip_sof,
    input  logic             ip_eof,
    input  logic             ip_valid,
    input  logic [7:0]       ip_protocol,
    input  logic [31:0]      ip_src_ip,
    input  logic [31:0]      ip_dst_ip,
    output logic [7:0]       s_udp_dout,
    output logic             s_udp_sof,
    output logic             s_udp_eof,
    output logic             s_udp_valid,
    output logic [15:0]      s_udp_src_port,
    output logic [15:0]      s_udp_dst_port,
    output logic [31:0]      s_udp_src_ip,
    output logic [31:0]      s_udp_dst_ip,
    output logic [15:0]      s_udp_len,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t           state_r;
    logic [2:0]       hdr_idx_r;
    logic [15:0]      src_port_r;
    logic [15:0]      dst_port_r;
    logic [15:0]      len_r;
    logic [CNT_W-1:0] pay_cnt_r;
    logic             drop_inc_r;
    logic             err_inc_r;

    logic start_s;
    logic is_udp_s;

    assign start_s  = ip_valid & ip_sof;
    assign is_udp_s = (ip_protocol == IPPROTO_UDP);

`ifdef UDP_LEN_CHECK_EN
    logic [15:0] pay_lim_s;
    logic        pay_last_s;

    assign pay_lim_s  = len_r - UDP_HDR_LEN;
    assign pay_last_s = (sat_inc(pay_cnt_r) == pay_lim_s);
`endif

    // Parser FSM with registered stream and metadata outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            hdr_idx_r      <= 3'd0;
            src_port_r     <= 16'h0000;
            dst_port_r     <= 16'h0000;
            len_r          <= 16'h0000;
            pay_cnt_r      <= {CNT_W{1'b0}};
            drop_inc_r     <= 1'b0;
            err_inc_r      <= 1'b0;
            s_udp_dout     <= 8'h00;
            s_udp_sof      <= 1'b0;
            s_udp_eof      <= 1'b0;
            s_udp_valid    <= 1'b0;
            s_udp_src_port <= 16'h0000;
            s_udp_dst_port <= 16'h0000;
            s_udp_src_ip   <= 32'h0000_0000;
            s_udp_dst_ip   <= 32'h0000_0000;
            s_udp_len      <= 16'h0000;
        end else begin
            s_udp_dout  <= 8'h00;
            s_udp_sof   <= 1'b0;
            s_udp_eof   <= 1'b0;
            s_udp_valid <= 1'b0;
            drop_inc_r  <= 1'b0;
            err_inc_r   <= 1'b0;

            if (start_s) begin
                // A new sof aborts whatever was in flight; an open frame gets a terminator byte.
                if (state_r == PAY) begin
                    err_inc_r <= 1'b1;
                    if (pay_cnt_r != {CNT_W{1'b0}}) begin
                        s_udp_valid <= 1'b1;
                        s_udp_eof   <= 1'b1;
                    end
                end
                hdr_idx_r        <= 3'd1;
                src_port_r[15:8] <= ip_dout;
                pay_cnt_r        <= {CNT_W{1'b0}};
                if (!is_udp_s) begin
                    drop_inc_r <= 1'b1;
                    state_r    <= ip_eof ? IDLE : SKIP;
                end else if (ip_eof) begin
                    drop_inc_r <= 1'b1;
                    state_r    <= IDLE;
                end else begin
                    state_r <= HDR;
                end
            end else if (ip_valid) begin
                case (state_r)
                    HDR: begin
                        case (hdr_idx_r)
                            3'd1:    src_port_r[7:0]  <= ip_dout;
                            3'd2:    dst_port_r[15:8] <= ip_dout;
                            3'd3:    dst_port_r[7:0]  <= ip_dout;
                            3'd4:    len_r[15:8]      <= ip_dout;
                            3'd5:    len_r[7:0]       <= ip_dout;
                            default: ;
                        endcase
                        hdr_idx_r <= hdr_idx_r + 3'd1;
                        if (ip_eof) begin
                            drop_inc_r <= 1'b1;
                            state_r    <= IDLE;
                        end else if (hdr_idx_r == 3'd7) begin
`ifdef UDP_LEN_CHECK_EN
                            if (len_r <= UDP_HDR_LEN) begin
                                drop_inc_r <= 1'b1;
                                state_r    <= SKIP;
                            end else begin
                                state_r <= PAY;
                            end
`else
                            state_r <= PAY;
`endif
                        end
                    end
                    PAY: begin
                        s_udp_valid <= 1'b1;
                        s_udp_dout  <= ip_dout;
                        s_udp_sof   <= (pay_cnt_r == {CNT_W{1'b0}});
                        // Saturation keeps a huge payload from ever looking like a first byte again.
                        pay_cnt_r   <= sat_inc(pay_cnt_r);
                        if (pay_cnt_r == {CNT_W{1'b0}}) begin
                            s_udp_src_port <= src_port_r;
                            s_udp_dst_port <= dst_port_r;
                            s_udp_len      <= len_r;
                            s_udp_src_ip   <= ip_src_ip;
                            s_udp_dst_ip   <= ip_dst_ip;
                        end
`ifdef UDP_LEN_CHECK_EN
                        if (pay_last_s) begin
                            s_udp_eof <= 1'b1;
                            state_r   <= ip_eof ? IDLE : SKIP;
                        end else if (ip_eof) begin
                            s_udp_eof <= 1'b1;
                            err_inc_r <= 1'b1;
                            state_r   <= IDLE;
                        end
`else
                        if (ip_eof) begin
                            s_udp_eof <= 1'b1;
                            state_r   <= IDLE;
                        end
`endif
                    end
                    SKIP: begin
                        if (ip_eof) begin
                            state_r <= IDLE;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    sat_cnt u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc_r),
        .count (drop_cnt)
    );

    sat_cnt u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc_r),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed and randomized-gap bench for udp_rx_parser with hand-computed expectations.
module tb_udp_rx_parser;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [7:0]  dout;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [15:0] len;
        logic [31:0] sip;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ip_dout = 8'h00;
    logic        ip_sof = 1'b0;
    logic        ip_eof = 1'b0;
    logic        ip_valid = 1'b0;
    logic [7:0]  ip_protocol = 8'd17;
    logic [31:0] ip_src_ip = 32'h0;
    logic [31:0] ip_dst_ip = 32'h0;
    logic [7:0]  s_udp_dout;
    logic        s_udp_sof, s_udp_eof, s_udp_valid;
    logic [15:0] s_udp_src_port, s_udp_dst_port, s_udp_len;
    logic [31:0] s_udp_src_ip, s_udp_dst_ip;
    logic [15:0] drop_cnt, err_cnt;

    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] frm[$];
    rec_t out_q[$];
    rec_t exp_q[$];

    udp_rx_parser dut (
        .clk            (clk),
        .rst            (rst),
        .ip_dout        (ip_dout),
        .ip_sof         (ip_sof),
        .ip_eof         (ip_eof),
        .ip_valid       (ip_valid),
        .ip_protocol    (ip_protocol),
        .ip_src_ip      (ip_src_ip),
        .ip_dst_ip      (ip_dst_ip),
        .s_udp_dout     (s_udp_dout),
        .s_udp_sof      (s_udp_sof),
        .s_udp_eof      (s_udp_eof),
        .s_udp_valid    (s_udp_valid),
        .s_udp_src_port (s_udp_src_port),
        .s_udp_dst_port (s_udp_dst_port),
        .s_udp_src_ip   (s_udp_src_ip),
        .s_udp_dst_ip   (s_udp_dst_ip),
        .s_udp_len      (s_udp_len),
        .drop_cnt       (drop_cnt),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    // Record every output byte together with the metadata visible alongside it.
    always @(negedge clk) begin
        if (s_udp_valid === 1'b1)
            out_q.push_back(rec_t'({s_udp_sof, s_udp_eof, s_udp_dout, s_udp_src_port,
                                    s_udp_dst_port, s_udp_len, s_udp_src_ip}));
    end

    task automatic drv(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk);
        ip_dout = d; ip_sof = s; ip_eof = e; ip_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ip_valid = 1'b0; ip_sof = 1'b0; ip_eof = 1'b0; ip_dout = 8'h00;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ip_valid = 1'b0; ip_sof = 1'b0; ip_eof = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_q.delete();
    endtask

    task automatic hdr(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len);
        frm.delete();
        frm.push_back(sp[15:8]); frm.push_back(sp[7:0]);
        frm.push_back(dp[15:8]); frm.push_back(dp[7:0]);
        frm.push_back(len[15:8]); frm.push_back(len[7:0]);
        frm.push_back(8'h5A); frm.push_back(8'hA5);
    endtask

    task automatic send_frm(input int gap_pct, input bit last_eof);
        for (int i = 0; i < frm.size(); i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
            drv(frm[i], i == 0, last_eof && (i == frm.size() - 1));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({s_udp_dout, s_udp_sof, s_udp_eof, s_udp_valid, s_udp_src_port, s_udp_dst_port,
             s_udp_src_ip, s_udp_dst_ip, s_udp_len} !== 139'd0) begin
            n_err++;
            $display("FAIL reset_outputs got valid=%b dout=%h sp=%h len=%h", s_udp_valid, s_udp_dout, s_udp_src_port, s_udp_len);
        end
        n_vec++;
        if ({drop_cnt, err_cnt} !== 32'd0) begin
            n_err++;
            $display("FAIL reset_counters got drop=%h err=%h exp 0 0", drop_cnt, err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [9:0] e [4] = '{10'h2DE, 10'h0AD, 10'h0BE, 10'h1EF};
        do_reset();
        ip_protocol = 8'd17; ip_src_ip = 32'hC0A8_0001; ip_dst_ip = 32'hC0A8_0002;
        hdr(16'h1388, 16'h1F90, 16'h000C);
        frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
        send_frm(0, 1'b1);
        @(negedge clk);
        n_vec++;
        if ({s_udp_valid, s_udp_eof, s_udp_dout} !== {1'b1, 1'b1, 8'hEF}) begin
            n_err++;
            $display("FAIL basic_latency got v=%b e=%b d=%h exp v=1 e=1 d=ef", s_udp_valid, s_udp_eof, s_udp_dout);
        end
        idle(4);
        n_vec++;
        if (out_q.size() != 4) begin
            n_err++;
            $display("FAIL basic_count got %0d exp 4", out_q.size());
        end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            n_vec++;
            if ({out_q[i].sof, out_q[i].eof, out_q[i].dout} !== e[i]) begin
                n_err++;
                $display("FAIL basic_byte[%0d] got %h exp %h", i, {out_q[i].sof, out_q[i].eof, out_q[i].dout}, e[i]);
            end
        end
        n_vec++;
        if ({s_udp_src_port, s_udp_dst_port, s_udp_len, s_udp_src_ip, s_udp_dst_ip} !==
            {16'h1388, 16'h1F90, 16'h000C, 32'hC0A8_0001, 32'hC0A8_0002}) begin
            n_err++;
            $display("FAIL basic_meta got sp=%h dp=%h len=%h sip=%h dip=%h", s_udp_src_port, s_udp_dst_port, s_udp_len, s_udp_src_ip, s_udp_dst_ip);
        end
    endtask

    task automatic test_non_udp();
        do_reset();
        ip_protocol = 8'd6;
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(8'(i + 1));
        send_frm(0, 1'b1);
        idle(4);
        n_vec++;
        if (out_q.size() != 0) begin
            n_err++;
            $display("FAIL non_udp_count got %0d exp 0", out_q.size());
        end
        n_vec++;
        if (drop_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL non_udp_drop got %0d exp 1", drop_cnt);
        end
        ip_protocol = 8'd17;
    endtask

    task automatic test_short_hdr();
        do_reset();
        hdr(16'h0001, 16'h0002, 16'h0010);
        for (int i = 0; i < 2; i++) void'(frm.pop_back());
        send_frm(0, 1'b1);
        idle(4);
        n_vec++;
        if (out_q.size() != 0 || drop_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL short_hdr got count=%0d drop=%0d exp 0 1", out_q.size(), drop_cnt);
        end
        hdr(16'h0001, 16'h0002, 16'h0008);
        send_frm(0, 1'b1);
        idle(4);
        n_vec++;
        if (out_q.size() != 0 || drop_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL zero_len got count=%0d drop=%0d exp 0 2", out_q.size(), drop_cnt);
        end
        hdr(16'h0003, 16'h0004, 16'h0009);
        frm.push_back(8'h55);
        send_frm(0, 1'b1);
        idle(4);
        n_vec++;
        if (out_q.size() != 1 || {out_q[0].sof, out_q[0].eof, out_q[0].dout} !== 10'h355) begin
            n_err++;
            $display("FAIL one_byte got count=%0d first=%h exp 1 355", out_q.size(),
                     out_q.size() > 0 ? {out_q[0].sof, out_q[0].eof, out_q[0].dout} : 10'h0);
        end
    endtask

    task automatic test_restart();
        logic [9:0] e [8] = '{10'h211, 10'h022, 10'h033, 10'h100, 10'h2DE, 10'h0AD, 10'h0BE, 10'h1EF};
        do_reset();
        hdr(16'h0001, 16'h0002, 16'h0012);
        frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33);
        send_frm(0, 1'b0);
        hdr(16'h1388, 16'h1F90, 16'h000C);
        frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
        send_frm(0, 1'b1);
        idle(4);
        n_vec++;
        if (out_q.size() != 8) begin
            n_err++;
            $display("FAIL restart_count got %0d exp 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_vec++;
            if ({out_q[i].sof, out_q[i].eof, out_q[i].dout} !== e[i]) begin
                n_err++;
                $display("FAIL restart_byte[%0d] got %h exp %h", i, {out_q[i].sof, out_q[i].eof, out_q[i].dout}, e[i]);
            end
        end
        n_vec++;
        if (err_cnt !== 16'd1 || s_udp_src_port !== 16'h1388) begin
            n_err++;
            $display("FAIL restart_err got err=%0d sp=%h exp 1 1388", err_cnt, s_udp_src_port);
        end
    endtask

`ifdef UDP_LEN_CHECK_EN
    task automatic test_len_check();
        logic [9:0] e [3] = '{10'h231, 10'h032, 10'h133};
        do_reset();
        hdr(16'h0007, 16'h0008, 16'h000A);
        frm.push_back(8'hA1); frm.push_back(8'hA2);
        for (int i = 0; i < 16; i++) frm.push_back(8'h00);
        send_frm(0, 1'b1);
        idle(4);
        n_vec++;
        if (out_q.size() != 2 || {out_q[0].sof, out_q[0].eof, out_q[0].dout} !== 10'h2A1 ||
            {out_q[1].sof, out_q[1].eof, out_q[1].dout} !== 10'h1A2 || err_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL len_trim got count=%0d err=%0d exp 2 0", out_q.size(), err_cnt);
        end
        out_q.delete();
        hdr(16'h0007, 16'h0008, 16'h0014);
        frm.push_back(8'h31); frm.push_back(8'h32); frm.push_back(8'h33);
        send_frm(0, 1'b1);
        idle(4);
        n_vec++;
        if (out_q.size() != 3 || err_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL len_short got count=%0d err=%0d exp 3 1", out_q.size(), err_cnt);
        end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            n_vec++;
            if ({out_q[i].sof, out_q[i].eof, out_q[i].dout} !== e[i]) begin
                n_err++;
                $display("FAIL len_short_byte[%0d] got %h exp %h", i, {out_q[i].sof, out_q[i].eof, out_q[i].dout}, e[i]);
            end
        end
    endtask
`else
    task automatic test_no_len_check();
        logic [9:0] e [5] = '{10'h261, 10'h062, 10'h063, 10'h064, 10'h165};
        do_reset();
        hdr(16'h0007, 16'h0008, 16'h000A);
        for (int i = 0; i < 5; i++) frm.push_back(8'(8'h61 + i));
        send_frm(0, 1'b1);
        idle(4);
        n_vec++;
        if (out_q.size() != 5 || s_udp_len !== 16'h000A) begin
            n_err++;
            $display("FAIL nolen_count got count=%0d len=%h exp 5 000a", out_q.size(), s_udp_len);
        end
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            n_vec++;
            if ({out_q[i].sof, out_q[i].eof, out_q[i].dout} !== e[i]) begin
                n_err++;
                $display("FAIL nolen_byte[%0d] got %h exp %h", i, {out_q[i].sof, out_q[i].eof, out_q[i].dout}, e[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] rv, sip;
        logic [15:0] sp, dp, len;
        logic [7:0]  b;
        int          n, n_drop;
        do_reset();
        exp_q.delete();
        n_drop = 0;
        for (int f = 0; f < 100; f++) begin
            n = $urandom_range(1, 20);
            rv = $urandom; sp = rv[15:0]; dp = rv[31:16];
            sip = $urandom;
            len = 16'(n + 8);
            ip_src_ip = sip; ip_dst_ip = ~sip;
            ip_protocol = ($urandom_range(0, 7) == 0) ? 8'd6 : 8'd17;
            hdr(sp, dp, len);
            for (int j = 0; j < n; j++) begin
                rv = $urandom; b = rv[7:0];
                frm.push_back(b);
                if (ip_protocol == 8'd17)
                    exp_q.push_back(rec_t'({j == 0, j == n - 1, b, sp, dp, len, sip}));
            end
            if (ip_protocol != 8'd17) n_drop++;
            send_frm(50, 1'b1);
            idle(1 + $urandom_range(0, 1));
        end
        idle(4);
        n_vec++;
        if (out_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand_count got %0d exp %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand_byte[%0d] got %h exp %h", i, out_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (drop_cnt !== 16'(n_drop) || err_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rand_cnt got drop=%0d err=%0d exp %0d 0", drop_cnt, err_cnt, n_drop);
        end
        ip_protocol = 8'd17;
    endtask

    task automatic test_rst_mid();
        logic [9:0] e [4] = '{10'h2DE, 10'h0AD, 10'h0BE, 10'h1EF};
        do_reset();
        ip_src_ip = 32'h0A00_0001; ip_dst_ip = 32'h0A00_0002;
        hdr(16'h1388, 16'h1F90, 16'h0020);
        frm.push_back(8'h01); frm.push_back(8'h02); frm.push_back(8'h03);
        send_frm(0, 1'b0);
        @(negedge clk);
        rst = 1'b1; ip_dout = 8'h04; ip_sof = 1'b0; ip_eof = 1'b1; ip_valid = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({s_udp_dout, s_udp_sof, s_udp_eof, s_udp_valid, s_udp_src_port, s_udp_dst_port,
             s_udp_src_ip, s_udp_dst_ip, s_udp_len, drop_cnt, err_cnt} !== 171'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs got valid=%b eof=%b sp=%h sip=%h drop=%h", s_udp_valid, s_udp_eof, s_udp_src_port, s_udp_src_ip, drop_cnt);
        end
        rst = 1'b0;
        ip_valid = 1'b0; ip_eof = 1'b0;
        out_q.delete();
        drv(8'h77, 1'b0, 1'b0);
        drv(8'h88, 1'b0, 1'b1);
        idle(2);
        hdr(16'h1388, 16'h1F90, 16'h000C);
        frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
        send_frm(0, 1'b1);
        idle(4);
        n_vec++;
        if (out_q.size() != 4 || err_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rst_mid_count got count=%0d err=%0d exp 4 0", out_q.size(), err_cnt);
        end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            n_vec++;
            if ({out_q[i].sof, out_q[i].eof, out_q[i].dout} !== e[i]) begin
                n_err++;
                $display("FAIL rst_mid_byte[%0d] got %h exp %h", i, {out_q[i].sof, out_q[i].eof, out_q[i].dout}, e[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_non_udp();
        test_short_hdr();
        test_restart();
`ifdef UDP_LEN_CHECK_EN
        test_len_check();
`else
        test_no_len_check();
`endif
        test_random();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
